// File: rtl/wos_sample_feeder.sv
// ============================================================================
// wos_sample_feeder
// ----------------------------------------------------------------------------
// Stream front-end for masked_rank_order. It takes a framed 1-D sample stream
// over a valid/ready handshake and drives the filter's `in` port with one
// sample per cycle. At each frame edge it adds PAD = (N-1)/2 padding samples,
// so every real sample ends up centred in a fully populated window.
//
// Parameters:
//   N          window length of the downstream filter (odd, >= 3)
//   data_bits  sample width
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   s_data      input sample
//   s_valid     s_data is valid
//   s_last      s_data is the final sample of the frame (only counts on accept)
//   s_ready     feeder can accept a sample this cycle (combinational from state)
//   f_in        sample driven into the filter (registered)
//   f_valid     f_in is new; the filter shifts this cycle (registered)
//   win_valid   window after this shift holds N frame-consistent samples
//   frame_done  one-cycle pulse on the final padded emission of a frame
//
// Build option:
//   FEEDER_ZERO_PAD_EN  when defined, padding emissions (lead copies after the
//                       first one, and all trail copies) drive f_in = 0 instead
//                       of replicating the edge sample.
// ============================================================================
module wos_sample_feeder #(
    parameter int N         = 11,
    parameter int data_bits = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_bits-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [data_bits-1:0] f_in,
    output logic                 f_valid,
    output logic                 win_valid,
    output logic                 frame_done
);

    localparam int PAD = (N - 1) / 2;
    localparam int CW  = $clog2(N + 1);
    localparam int PW  = $clog2(PAD + 1);

    localparam logic [CW-1:0] N_CNT   = CW'(N);
    localparam logic [PW-1:0] PAD_CNT = PW'(PAD);
    localparam logic [PW-1:0] PAD_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        STREAM,
        TRAIL
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        emit_cnt, emit_cnt_nxt, cnt_inc;
    logic [PW-1:0]        pad_cnt, pad_cnt_nxt;
    logic [data_bits-1:0] edge_q, edge_nxt;
    logic [data_bits-1:0] f_in_nxt;
    logic [data_bits-1:0] pad_data;
    logic                 last_q, last_nxt;
    logic                 emit;
    logic                 frame_done_nxt;
    logic                 accept;

    assign s_ready = (state == IDLE) || (state == STREAM);
    assign accept  = s_valid && s_ready;

`ifdef FEEDER_ZERO_PAD_EN
    assign pad_data = '0;
`else
    assign pad_data = edge_q;
`endif

    // Saturating emission count; the window is full once N samples of the
    // current frame have been shifted in, and stays full until the frame ends.
    assign cnt_inc = (emit_cnt == N_CNT) ? emit_cnt : emit_cnt + 1'b1;

    always_comb begin
        state_nxt      = state;
        pad_cnt_nxt    = pad_cnt;
        edge_nxt       = edge_q;
        last_nxt       = last_q;
        f_in_nxt       = f_in;
        emit           = 1'b0;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    emit        = 1'b1;
                    f_in_nxt    = s_data;
                    edge_nxt    = s_data;
                    pad_cnt_nxt = PAD_CNT;
                    last_nxt    = s_last;
                    state_nxt   = LEAD;
                end
            end
            LEAD: begin
                emit     = 1'b1;
                f_in_nxt = pad_data;
                if (pad_cnt == PAD_ONE) begin
                    // A single-sample frame skips STREAM and pads straight out.
                    pad_cnt_nxt = PAD_CNT;
                    state_nxt   = last_q ? TRAIL : STREAM;
                end else begin
                    pad_cnt_nxt = pad_cnt - 1'b1;
                end
            end
            STREAM: begin
                if (accept) begin
                    emit     = 1'b1;
                    f_in_nxt = s_data;
                    edge_nxt = s_data;
                    if (s_last) begin
                        pad_cnt_nxt = PAD_CNT;
                        state_nxt   = TRAIL;
                    end
                end
            end
            TRAIL: begin
                emit        = 1'b1;
                f_in_nxt    = pad_data;
                pad_cnt_nxt = pad_cnt - 1'b1;
                if (pad_cnt == PAD_ONE) begin
                    frame_done_nxt = 1'b1;
                    state_nxt      = IDLE;
                end
            end
        endcase

        emit_cnt_nxt = emit ? cnt_inc : emit_cnt;
        if ((state_nxt == IDLE) && (state != IDLE)) begin
            emit_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            f_in       <= '0;
            f_valid    <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            emit_cnt   <= '0;
            pad_cnt    <= '0;
            edge_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            f_in       <= f_in_nxt;
            f_valid    <= emit;
            win_valid  <= emit && (cnt_inc == N_CNT);
            frame_done <= frame_done_nxt;
            emit_cnt   <= emit_cnt_nxt;
            pad_cnt    <= pad_cnt_nxt;
            edge_q     <= edge_nxt;
            last_q     <= last_nxt;
        end
    end

endmodule

// File: tb/tb_wos_sample_feeder.sv
// ============================================================================
// tb_wos_sample_feeder
// ----------------------------------------------------------------------------
// Scoreboard bench for wos_sample_feeder (N = 11, PAD = 5). A frame-level
// reference model turns every accepted sample into the list of emissions the
// filter must see (cycle, data, win_valid, frame_done); a monitor pops and
// compares them whenever the feeder drives f_valid.
// ============================================================================
module tb_wos_sample_feeder;

    localparam int N   = 11;
    localparam int PAD = (N - 1) / 2;
    localparam int DW  = 8;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic          s_ready;
    logic [DW-1:0] f_in;
    logic          f_valid;
    logic          win_valid;
    logic          frame_done;

    typedef struct {
        int cyc;
        int data;
        bit win;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   frame_q[$];

    int cyc         = 0;
    int assertions  = 0;
    int failures    = 0;
    int busy_until  = 0;
    bit in_frame    = 0;
    int frame_emits = 0;
    int last_e      = 0;
    int edge_val    = 0;

    wos_sample_feeder #(
        .N         (N),
        .data_bits (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .f_in       (f_in),
        .f_valid    (f_valid),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: actual %0d required %0d",
                     name, cyc, actual, expected);
        end
    endtask

    function automatic int padVal(input int v);
`ifdef FEEDER_ZERO_PAD_EN
        return 0;
`else
        return v;
`endif
    endfunction

    // The window is full once N samples of this frame have been shifted in.
    function automatic void pushEmit(input int c, input int d, input bit done);
        frame_emits++;
        exp_q.push_back('{cyc: c, data: d, win: (frame_emits >= N), done: done});
    endfunction

    function automatic void pushTrail();
        for (int i = 1; i <= PAD; i++) begin
            pushEmit(last_e + i, padVal(edge_val), i == PAD);
        end
        last_e = last_e + PAD;
    endfunction

    // Reference model: samples the handshake half a cycle before the edge
    // that takes it, so every emission it predicts lies in the future.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            exp_q.delete();
            in_frame    = 0;
            busy_until  = 0;
            frame_emits = 0;
        end else begin
            checkOutput("s_ready", s_ready, (cyc >= busy_until));
            if (s_valid && s_ready) begin
                int c;
                c = cyc + 1;
                edge_val = int'(s_data);
                if (!in_frame) begin
                    frame_emits = 0;
                    pushEmit(c, int'(s_data), 0);
                    for (int i = 1; i <= PAD; i++) pushEmit(c + i, padVal(int'(s_data)), 0);
                    last_e     = c + PAD;
                    busy_until = c + PAD;
                    in_frame   = 1;
                end else begin
                    pushEmit(c, int'(s_data), 0);
                    last_e = c;
                end
                if (s_last) begin
                    pushTrail();
                    busy_until = last_e;
                    in_frame   = 0;
                end
            end
        end
    end

    // Monitor: compares every emission against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            checkOutput("reset_outputs", {f_valid, win_valid, frame_done}, 0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checkOutput("emit_missing", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (f_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("emit_unexpected", f_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("emit_cycle", cyc, mon_e.cyc);
                    checkOutput("f_in", f_in, mon_e.data);
                    checkOutput("win_valid", win_valid, mon_e.win);
                    checkOutput("frame_done", frame_done, mon_e.done);
                end
            end else begin
                checkOutput("idle_flags", {win_valid, frame_done}, 0);
            end
        end
    end

    // Sends frame_q; mode 0 = valid always high, 1 = toggled, 2 = random.
    // Returns half a cycle before the edge that takes the last sample.
    task automatic applyStimulus(input int mode);
        int idx;
        int guard;
        bit phase;
        idx   = 0;
        guard = 0;
        phase = 1;
        while (idx < frame_q.size() && guard < 2000) begin
            @(posedge clk);
            #2;
            guard++;
            case (mode)
                0:       s_valid = 1'b1;
                1:       begin s_valid = phase; phase = !phase; end
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            if (s_valid) begin
                s_data = DW'(frame_q[idx]);
                s_last = (idx == frame_q.size() - 1);
            end else begin
                s_data = DW'($urandom);
                s_last = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (s_valid && s_ready) idx++;
        end
        if (idx < frame_q.size()) checkOutput("stim_timeout", idx, frame_q.size());
    endtask

    task automatic goIdle();
        @(posedge clk);
        #2;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drain", exp_q.size(), 0);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic randomFrame(input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(int'($urandom_range(0, 255)));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;

        $display("[TB] frame 10,20,30 with valid held high");
        frame_q = '{10, 20, 30};
        applyStimulus(0);
        goIdle();
        waitDrain();

        $display("[TB] single-sample frame");
        frame_q = '{7};
        applyStimulus(0);
        goIdle();
        waitDrain();

        $display("[TB] 20-sample frame with toggled valid");
        randomFrame(20);
        applyStimulus(1);
        goIdle();
        waitDrain();

        $display("[TB] reset during trail, then frame 1,2");
        frame_q = '{50, 60, 70};
        applyStimulus(0);
        goIdle();
        repeat (2) @(posedge clk);
        pulseReset();
        frame_q = '{1, 2};
        applyStimulus(0);
        goIdle();
        waitDrain();

        $display("[TB] back-to-back frames");
        randomFrame(4);
        applyStimulus(0);
        randomFrame(3);
        applyStimulus(0);
        randomFrame(1);
        applyStimulus(0);
        goIdle();
        waitDrain();

        $display("[TB] randomized frames");
        for (int f = 0; f < 6; f++) begin
            randomFrame(int'($urandom_range(1, 15)));
            applyStimulus(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 0) goIdle();
        end
        goIdle();
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
